// File: rtl/ringosc_freq_meter_pkg.sv
// Shared types and Gray-code helpers for the ring-oscillator frequency meter.
// Helpers work on 32-bit values; callers zero-extend and truncate to their own width.
package ringosc_freq_meter_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } meter_state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ringosc_gray_counter.sv
// Edge counter clocked by the ring oscillator; exports its count as registered Gray code
// so the CLK domain can sample it with at most one bit in flight.
module ringosc_gray_counter
  import ringosc_freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W = 20
) (
  input  logic             osc_in,
  input  logic             reset,
  output logic [CNT_W-1:0] gray_count
);

  logic [CNT_W-1:0] bin_q;
  logic [CNT_W-1:0] bin_next;

  assign bin_next = bin_q + CNT_W'(1);

  always_ff @(posedge osc_in or posedge reset) begin
    if (reset) begin
      bin_q      <= '0;
      gray_count <= '0;
    end else begin
      bin_q      <= bin_next;
      gray_count <= CNT_W'(bin2gray(32'(bin_next)));
    end
  end

endmodule

// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter: CDC of the Gray edge count, gate-window timer,
// WARMUP/RUN control and a valid/ready sample register. Optional macro: RINGOSC_DROP_ALARM_EN.
module ringosc_freq_meter
  import ringosc_freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned GATE_CYCLES    = 65536,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DROP_THRESHOLD = 5
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             osc_in,
  input  logic             enable,
  output logic [CNT_W-1:0] sample_count,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             drop_alarm
);

  localparam int unsigned TIMER_W = $clog2(GATE_CYCLES);

  if (GATE_CYCLES < 16 || SYNC_STAGES < 2 || 64'(DROP_THRESHOLD) >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("ringosc_freq_meter: unsupported parameter combination");
  end

  logic [CNT_W-1:0]   gray_count;
  logic [CNT_W-1:0]   sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]   snap;
  logic [CNT_W-1:0]   prev_q;
  logic [CNT_W-1:0]   delta;
  logic [TIMER_W-1:0] timer_q;
  logic               win_end;
  meter_state_t       state_q, state_d;
  logic               take_prev, load, timer_clr;

  ringosc_gray_counter #(.CNT_W(CNT_W)) u_counter (
    .osc_in     (osc_in),
    .reset      (reset),
    .gray_count (gray_count)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_count;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign snap    = CNT_W'(gray2bin(32'(sync_q[SYNC_STAGES-1])));
  assign delta   = snap - prev_q;
  assign win_end = (timer_q == TIMER_W'(GATE_CYCLES - 1));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      state_q <= WARMUP;
      prev_q  <= '0;
    end else begin
      timer_q <= (timer_clr || win_end) ? '0 : timer_q + TIMER_W'(1);
      state_q <= state_d;
      if (take_prev) prev_q <= snap;
    end
  end

  // Disabling in RUN wins over a coincident window end: no sample from that window.
  always_comb begin
    state_d   = state_q;
    take_prev = 1'b0;
    load      = 1'b0;
    timer_clr = 1'b0;
    case (state_q)
      WARMUP: begin
        if (win_end && enable) begin
          state_d   = RUN;
          take_prev = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d   = WARMUP;
          timer_clr = 1'b1;
        end else if (win_end) begin
          load      = 1'b1;
          take_prev = 1'b1;
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sample_count <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      sample_count <= delta;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

`ifdef RINGOSC_DROP_ALARM_EN
  logic [CNT_W-1:0] last_delta;
  logic             have_last;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      last_delta <= '0;
      have_last  <= 1'b0;
      drop_alarm <= 1'b0;
    end else begin
      drop_alarm <= 1'b0;
      if (timer_clr) have_last <= 1'b0;
      if (load) begin
        last_delta <= delta;
        have_last  <= 1'b1;
        drop_alarm <= have_last &&
                      ({1'b0, last_delta} > ({1'b0, delta} + (CNT_W+1)'(DROP_THRESHOLD)));
      end
    end
  end
`else
  assign drop_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed bench for ringosc_freq_meter: 10 ns and 5 ns oscillators against an 83.33 ns CLK, 64-cycle gate.
`timescale 1ns/1ps
module tb_ringosc_freq_meter;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        osc_a = 1'b0;
  logic        osc_b = 1'b0;
  logic        enable = 1'b0;
  logic        ready = 1'b0;
  logic [19:0] sample_count;
  logic        sample_valid, overrun, drop_alarm;
  logic [7:0]  count_b;
  logic        valid_b, overrun_b, drop_b;
  realtime     osc_half_a = 5.0;
  realtime     osc_half_b = 2.5;
  int          checks = 0;
  int          errors = 0;

  always #41.665 CLK = ~CLK;
  always begin #(osc_half_a); osc_a = ~osc_a; end
  always begin #(osc_half_b); osc_b = ~osc_b; end

  ringosc_freq_meter #(.CNT_W(20), .GATE_CYCLES(64), .SYNC_STAGES(2), .DROP_THRESHOLD(5)) dut (
    .CLK(CLK), .reset(reset), .osc_in(osc_a), .enable(enable),
    .sample_count(sample_count), .sample_valid(sample_valid), .sample_ready(ready),
    .overrun(overrun), .drop_alarm(drop_alarm)
  );

  ringosc_freq_meter #(.CNT_W(8), .GATE_CYCLES(64), .SYNC_STAGES(2), .DROP_THRESHOLD(5)) dut_wrap (
    .CLK(CLK), .reset(reset), .osc_in(osc_b), .enable(1'b1),
    .sample_count(count_b), .sample_valid(valid_b), .sample_ready(1'b1),
    .overrun(overrun_b), .drop_alarm(drop_b)
  );

  task automatic wait_valid(input int budget, output int cycles, output bit ok);
    ok = 0;
    cycles = 0;
    while (!ok && cycles < budget) begin
      @(posedge CLK); #1;
      cycles++;
      if (sample_valid) ok = 1;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (sample_count !== 20'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sample_count); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (drop_alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b want 0", drop_alarm); end
    enable = 1'b1;
    ready  = 1'b1;
    @(negedge CLK) reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc; bit ok;
    for (int n = 0; n < 3; n++) begin
      wait_valid(200, cyc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout sample %0d valid=%b want 1", n, sample_valid); end
      else if (sample_count < 532 || sample_count > 535) begin
        errors++; $display("FAIL basic_count sample %0d got %0d want 532..535", n, sample_count);
      end
      @(posedge CLK); #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL basic_accept got valid=%b want 0", sample_valid); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b want 0", overrun); end
  endtask

  task automatic test_backpressure;
    int cyc; bit ok, hold_ok;
    logic [19:0] v0, v1;
    ready = 1'b0;
    wait_valid(200, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout valid=%b want 1", sample_valid); end
    v0 = sample_count;
    hold_ok = 1;
    repeat (62) begin
      @(posedge CLK); #1;
      if (sample_count !== v0 || sample_valid !== 1'b1 || overrun !== 1'b0) hold_ok = 0;
    end
    checks++; if (!hold_ok) begin errors++; $display("FAIL bp_hold got count=%0d valid=%b want count=%0d valid=1", sample_count, sample_valid, v0); end
    repeat (100) begin @(posedge CLK); #1; end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", sample_valid); end
    checks++;
    if (sample_count < 532 || sample_count > 535) begin errors++; $display("FAIL bp_latest got %0d want 532..535", sample_count); end
    v1 = sample_count;
    ready = 1'b1;
    @(posedge CLK); #1;
    ready = 1'b0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_valid got %b want 0", sample_valid); end
    checks++; if (sample_count !== v1) begin errors++; $display("FAIL bp_accept_count got %0d want %0d", sample_count, v1); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b want 1", overrun); end
    ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    int cyc; bit ok;
    repeat (20) @(posedge CLK);
    @(negedge CLK) reset = 1'b1;
    #1;
    checks++; if (sample_count !== 20'd0) begin errors++; $display("FAIL mid_count got %0d want 0", sample_count); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", sample_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b want 0", overrun); end
    @(negedge CLK) reset = 1'b0;
    wait_valid(200, cyc, ok);
    checks++; if (!ok || cyc != 128) begin errors++; $display("FAIL mid_first_sample got cycle %0d want 128", cyc); end
    checks++;
    if (sample_count < 532 || sample_count > 535) begin errors++; $display("FAIL mid_count_after got %0d want 532..535", sample_count); end
  endtask

  task automatic test_enable;
    int cyc; bit ok, seen;
    @(posedge CLK); #1;
    enable = 1'b0;
    repeat (2) @(posedge CLK);
    seen = 0;
    repeat (128) begin @(posedge CLK); #1; if (sample_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL en_disabled got valid=1 want 0"); end
    enable = 1'b1;
    seen = 0;
    repeat (64) begin @(posedge CLK); #1; if (sample_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL en_warmup got valid=1 want 0"); end
    wait_valid(100, cyc, ok);
    checks++;
    if (!ok || sample_count < 532 || sample_count > 535) begin
      errors++; $display("FAIL en_resume got valid=%b count=%0d want 1 and 532..535", sample_valid, sample_count);
    end
  endtask

  task automatic test_wrap;
    for (int n = 0; n < 2; n++) begin
      int cyc;
      cyc = 0;
      while (!valid_b && cyc < 200) begin @(posedge CLK); #1; cyc++; end
      checks++;
      if (!valid_b || count_b < 41 || count_b > 44) begin
        errors++; $display("FAIL wrap_count sample %0d got valid=%b count=%0d want 1 and 41..44", n, valid_b, count_b);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_drop_alarm;
    int cyc, pulses, exp_pulses;
    bit ok;
    logic [19:0] last;
`ifdef RINGOSC_DROP_ALARM_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    wait_valid(200, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout valid=%b want 1", sample_valid); end
    pulses = 0;
    // Switch at the edge the synchroniser uses as the next window boundary.
    repeat (62) begin @(posedge CLK); #1; pulses += int'(drop_alarm); end
    osc_half_a = 6.0;
    last = '0;
    repeat (192) begin
      @(posedge CLK); #1;
      pulses += int'(drop_alarm);
      if (sample_valid) last = sample_count;
    end
    checks++; if (pulses != exp_pulses) begin errors++; $display("FAIL drop_pulses got %0d want %0d", pulses, exp_pulses); end
    checks++; if (last < 442 || last > 446) begin errors++; $display("FAIL drop_slow_count got %0d want 442..446", last); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_reset_mid;
    test_enable;
    test_wrap;
    test_drop_alarm;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
